// File: rtl/atom_cfg_pkg.sv
// Shared types for the nested-if atom configuration bundle and its stream loader.
// Build option: ATOM_CFG_CHECKSUM_EN appends an XOR integrity word to each frame.
package atom_cfg_pkg;

  typedef logic signed [31:0] int32_t;
  typedef logic signed [1:0]  int2_t;
  typedef logic               bool_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NCONS  = 11;
  localparam int unsigned NSEL_B = 13;
  localparam int unsigned NSEL_I = 8;
  localparam int unsigned NREL   = 3;
  localparam int unsigned NARITH = 4;

  localparam int unsigned CTRL0_IDX = 11;
  localparam int unsigned CTRL1_IDX = 12;
  localparam int unsigned NDATA     = 13;
`ifdef ATOM_CFG_CHECKSUM_EN
  localparam int unsigned NWORDS    = 14;
`else
  localparam int unsigned NWORDS    = 13;
`endif

  localparam int unsigned CTRL0_SELB_LSB  = 0;
  localparam int unsigned CTRL0_SELI_LSB  = 13;
  localparam int unsigned CTRL1_REL_LSB   = 0;
  localparam int unsigned CTRL1_ARITH_LSB = 6;

  // cons[0]=cons_1; sel_b[n] = n-th of bool sels 1,2,3,4,5,6,7,10,13,14,15,16,19;
  // sel_i[n] = n-th of int2 sels 8,9,11,12,17,18,20,21; rel_op[0]=rel_op1, arith_op[0]=arith_op1.
  typedef struct packed {
    int32_t [NCONS-1:0]   cons;
    int2_t  [NSEL_I-1:0]  sel_i;
    bool_t  [NSEL_B-1:0]  sel_b;
    logic   [NREL-1:0][1:0] rel_op;
    logic   [NARITH-1:0]  arith_op;
  } atom_cfg_t;

  localparam int unsigned CFG_W = $bits(atom_cfg_t);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} fsm_e;

endpackage

// File: rtl/atom_cfg_unpack.sv
// Splits the two control words of a frame into select and opcode fields.
module atom_cfg_unpack
  import atom_cfg_pkg::*;
(
  input  logic [WORD_W-1:0]    ctrl0,
  input  logic [WORD_W-1:0]    ctrl1,
  output bool_t [NSEL_B-1:0]   sel_b,
  output int2_t [NSEL_I-1:0]   sel_i,
  output logic [NREL-1:0][1:0] rel_op,
  output logic [NARITH-1:0]    arith_op
);

  assign sel_b    = ctrl0[CTRL0_SELB_LSB +: NSEL_B];
  assign sel_i    = ctrl0[CTRL0_SELI_LSB +: 2*NSEL_I];
  assign rel_op   = ctrl1[CTRL1_REL_LSB +: 2*NREL];
  assign arith_op = ctrl1[CTRL1_ARITH_LSB +: NARITH];

  // Reserved control bits are accepted and ignored.
  logic unused_bits;
  assign unused_bits = ^{ctrl0[WORD_W-1:CTRL0_SELI_LSB+2*NSEL_I],
                         ctrl1[WORD_W-1:CTRL1_ARITH_LSB+NARITH]};

endmodule

// File: rtl/atom_cfg_loader.sv
// Valid/ready loader: fills a shadow frame and commits it atomically at a packet boundary.
// Build option: ATOM_CFG_CHECKSUM_EN adds a trailing XOR word checked before commit.
module atom_cfg_loader
  import atom_cfg_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    i__cfg_data,
  input  logic                 i__cfg_valid,
  input  logic                 i__cfg_last,
  output logic                 o__cfg_ready,
  input  logic                 i__commit_en,
  output atom_cfg_t            o__cfg,
  output logic                 o__cfg_loaded,
  output logic                 o__commit,
  output logic                 o__frame_err,
  output logic [ERR_CNT_W-1:0] o__err_cnt
);

  localparam int unsigned IDX_W = $clog2(NWORDS);

  fsm_e              state_q, state_d;
  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] shadow [NDATA];
  logic              accept, is_final, csum_ok, do_commit, do_err;
  atom_cfg_t         cfg_new;

  bool_t [NSEL_B-1:0]   u_sel_b;
  int2_t [NSEL_I-1:0]   u_sel_i;
  logic [NREL-1:0][1:0] u_rel_op;
  logic [NARITH-1:0]    u_arith_op;

  assign accept   = i__cfg_valid && o__cfg_ready;
  assign is_final = (word_idx == IDX_W'(NWORDS-1));

`ifdef ATOM_CFG_CHECKSUM_EN
  logic [DATA_W-1:0] xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xor_q <= '0;
    else if (accept)
      xor_q <= (is_final || do_err) ? '0 : (xor_q ^ i__cfg_data);
  end

  assign csum_ok = (xor_q == i__cfg_data);
`else
  assign csum_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    do_err    = 1'b0;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          // last must coincide exactly with the final word, and the checksum must match.
          if ((i__cfg_last != is_final) || (is_final && !csum_ok)) begin
            do_err  = 1'b1;
            state_d = IDLE;
          end else if (is_final) begin
            state_d = PEND;
          end else begin
            state_d = LOAD;
          end
        end
      end
      PEND: begin
        if (i__commit_en) begin
          do_commit = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx <= '0;
      for (int unsigned k = 0; k < NDATA; k++) shadow[k] <= '0;
    end else if (accept) begin
      word_idx <= (is_final || do_err) ? '0 : word_idx + 1'b1;
      if (word_idx < IDX_W'(NDATA)) shadow[word_idx] <= i__cfg_data;
    end
  end

  atom_cfg_unpack u_unpack (
    .ctrl0    (shadow[CTRL0_IDX]),
    .ctrl1    (shadow[CTRL1_IDX]),
    .sel_b    (u_sel_b),
    .sel_i    (u_sel_i),
    .rel_op   (u_rel_op),
    .arith_op (u_arith_op)
  );

  always_comb begin
    cfg_new = '0;
    for (int unsigned k = 0; k < NCONS; k++) cfg_new.cons[k] = shadow[k];
    cfg_new.sel_b    = u_sel_b;
    cfg_new.sel_i    = u_sel_i;
    cfg_new.rel_op   = u_rel_op;
    cfg_new.arith_op = u_arith_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o__cfg        <= '0;
      o__cfg_loaded <= 1'b0;
      o__commit     <= 1'b0;
      o__frame_err  <= 1'b0;
      o__err_cnt    <= '0;
      o__cfg_ready  <= 1'b0;
    end else begin
      o__commit    <= do_commit;
      o__frame_err <= do_err;
      o__cfg_ready <= (state_d != PEND);
      if (do_commit) begin
        o__cfg        <= cfg_new;
        o__cfg_loaded <= 1'b1;
      end
      if (do_err && (o__err_cnt != '1)) o__err_cnt <= o__err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_atom_cfg_loader.sv
// Directed bench for atom_cfg_loader with a commit scoreboard; covers ATOM_CFG_CHECKSUM_EN when defined.
module tb_atom_cfg_loader;
  import atom_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i__cfg_data;
  logic        i__cfg_valid;
  logic        i__cfg_last;
  logic        o__cfg_ready;
  logic        i__commit_en;
  atom_cfg_t   o__cfg;
  logic        o__cfg_loaded;
  logic        o__commit;
  logic        o__frame_err;
  logic [7:0]  o__err_cnt;

  atom_cfg_loader #(.DATA_W(32), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i__cfg_data   (i__cfg_data),
    .i__cfg_valid  (i__cfg_valid),
    .i__cfg_last   (i__cfg_last),
    .o__cfg_ready  (o__cfg_ready),
    .i__commit_en  (i__commit_en),
    .o__cfg        (o__cfg),
    .o__cfg_loaded (o__cfg_loaded),
    .o__commit     (o__commit),
    .o__frame_err  (o__frame_err),
    .o__err_cnt    (o__err_cnt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned n_commit = 0;
  atom_cfg_t   sb[$];
  atom_cfg_t   cur_cfg = '0;
  int unsigned exp_err = 0;
  logic [31:0] fw [NWORDS];

  // 0: commit_en low, 1: high, 2: random
  int unsigned commit_mode = 1;
  logic        rand_bit = 1'b0;
  assign i__commit_en = (commit_mode == 2) ? rand_bit : (commit_mode == 1);
  always @(negedge clk) rand_bit <= ($urandom_range(0, 2) == 0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input atom_cfg_t exp);
    checks++;
    assert (o__cfg === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o__cfg, exp);
    end
  endtask

  function automatic atom_cfg_t model();
    atom_cfg_t   c;
    logic [31:0] c0, c1;
    c  = '0;
    c0 = fw[11];
    c1 = fw[12];
    for (int k = 0; k < 11; k++) c.cons[k] = fw[k];
    for (int b = 0; b < 13; b++) c.sel_b[b] = c0[b];
    for (int i = 0; i < 8; i++)  c.sel_i[i] = c0[13 + 2*i +: 2];
    for (int r = 0; r < 3; r++)  c.rel_op[r] = c1[2*r +: 2];
    c.arith_op = c1[9:6];
    return c;
  endfunction

  task automatic fill_frame(input bit directed);
    logic [31:0] x;
    for (int k = 0; k < 13; k++) fw[k] = directed ? 32'(k + 1) : $urandom;
    if (directed) begin
      fw[11] = 32'h1FFF_FFFF;
      fw[12] = 32'h0000_03FF;
    end
    x = '0;
    for (int k = 0; k < 13; k++) x = x ^ fw[k];
    if (NWORDS > 13) fw[NWORDS-1] = x;
  endtask

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic send_word(input logic [31:0] d, input logic l);
    int unsigned n = 0;
    i__cfg_data  = d;
    i__cfg_last  = l;
    i__cfg_valid = 1'b1;
    while (!o__cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      failures++;
      $error("FAIL ready_timeout observed=%0d expected=<200", n);
    end
    @(negedge clk);
    i__cfg_valid = 1'b0;
    i__cfg_last  = 1'b0;
  endtask

  // last_at >= NWORDS sends a full frame without any last flag.
  task automatic send_frame(input int unsigned last_at, input bit gaps, input bit expect_commit);
    int unsigned nw;
    nw = (last_at < NWORDS) ? last_at + 1 : NWORDS;
    if (expect_commit) sb.push_back(model());
    for (int unsigned k = 0; k < nw; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(fw[k], k == last_at);
    end
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    chk_cfg({tag, "_cfg"}, cur_cfg);
  endtask

  task automatic expect_err(input string tag);
    chk({tag, "_pulse"}, 64'(o__frame_err), 64'd1);
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    chk({tag, "_cnt"}, 64'(o__err_cnt), 64'(exp_err));
  endtask

  always @(negedge clk) begin
    if (rst_n && o__commit) begin
      n_commit++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_commit observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        cur_cfg = sb.pop_front();
        checks++;
        assert (o__cfg === cur_cfg) else begin
          failures++;
          $error("FAIL commit_cfg observed=%h expected=%h", o__cfg, cur_cfg);
        end
        checks++;
        assert (o__cfg_loaded === 1'b1) else begin
          failures++;
          $error("FAIL commit_loaded observed=%b expected=1", o__cfg_loaded);
        end
      end
    end
  end

  initial begin
    int unsigned n0;
    i__cfg_data  = '0;
    i__cfg_valid = 1'b0;
    i__cfg_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk_cfg("rst_cfg", '0);
    chk("rst_loaded", 64'(o__cfg_loaded), 64'd0);
    chk("rst_ready", 64'(o__cfg_ready), 64'd0);
    chk("rst_commit", 64'(o__commit), 64'd0);
    chk("rst_frame_err", 64'(o__frame_err), 64'd0);
    chk("rst_err_cnt", 64'(o__err_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: directed frame, immediate commit
    fill_frame(1'b1);
    send_frame(NWORDS-1, 1'b0, 1'b1);
    chk("t1_commit_early", 64'(o__commit), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_commit", 64'(o__commit), 64'd1);
    chk("t1_cons5", 64'(o__cfg.cons[4]), 64'd5);
    chk("t1_sel_b", 64'(o__cfg.sel_b), 64'h1FFF);
    chk("t1_sel_i", 64'(o__cfg.sel_i), 64'hFFFF);
    chk("t1_rel", 64'(o__cfg.rel_op), 64'h3F);
    chk("t1_arith", 64'(o__cfg.arith_op), 64'hF);
    chk("t1_loaded", 64'(o__cfg_loaded), 64'd1);
    chk("t1_ready_back", 64'(o__cfg_ready), 64'd1);

    // 2: commit held off for 10 cycles
    commit_mode = 0;
    fill_frame(1'b0);
    n0 = n_commit;
    send_frame(NWORDS-1, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("t2_ready_low", 64'(o__cfg_ready), 64'd0);
      chk_cfg("t2_cfg_hold", cur_cfg);
    end
    chk("t2_no_commit", 64'(n_commit), 64'(n0));
    commit_mode = 1;
    @(negedge clk);
    #1;
    chk("t2_commit_pulse", 64'(o__commit), 64'd1);
    chk("t2_commit_count", 64'(n_commit), 64'(n0 + 1));

    // 3: early last, then missing last, then a good frame
    fill_frame(1'b0);
    send_frame(7, 1'b0, 1'b0);
    expect_err("t3_early_last");
    chk_cfg("t3_cfg_kept", cur_cfg);
    fill_frame(1'b0);
    send_frame(NWORDS, 1'b0, 1'b0);
    expect_err("t3_no_last");
    fill_frame(1'b0);
    send_frame(NWORDS-1, 1'b0, 1'b1);
    wait_drain("t3_drain");

    // 4: gaps and random commit backpressure
    commit_mode = 2;
    n0 = n_commit;
    for (int f = 0; f < 4; f++) begin
      fill_frame(1'b0);
      send_frame(NWORDS-1, 1'b1, 1'b1);
    end
    commit_mode = 1;
    wait_drain("t4_drain");
    chk("t4_commit_count", 64'(n_commit), 64'(n0 + 4));

    // 5: reset in mid-frame
    fill_frame(1'b0);
    for (int k = 0; k < 6; k++) send_word(fw[k], 1'b0);
    i__cfg_data  = fw[6];
    i__cfg_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_cfg("t5_cfg_zero", '0);
    chk("t5_loaded", 64'(o__cfg_loaded), 64'd0);
    chk("t5_ready", 64'(o__cfg_ready), 64'd0);
    i__cfg_valid = 1'b0;
    cur_cfg = '0;
    exp_err = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_ready_in_rst", 64'(o__cfg_ready), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    fill_frame(1'b0);
    send_frame(NWORDS-1, 1'b0, 1'b1);
    wait_drain("t5_drain");
    chk("t5_loaded_again", 64'(o__cfg_loaded), 64'd1);

`ifdef ATOM_CFG_CHECKSUM_EN
    // 6: checksum word
    n0 = n_commit;
    fill_frame(1'b0);
    fw[NWORDS-1] = fw[NWORDS-1] ^ 32'd1;
    send_frame(NWORDS-1, 1'b0, 1'b0);
    expect_err("t6_bad_xor");
    repeat (2) @(negedge clk);
    chk("t6_no_commit", 64'(n_commit), 64'(n0));
    fill_frame(1'b0);
    send_frame(NWORDS-1, 1'b0, 1'b1);
    wait_drain("t6_good_xor");
    for (int f = 0; f < 300; f++) begin
      fill_frame(1'b0);
      fw[NWORDS-1] = fw[NWORDS-1] ^ 32'd1;
      send_frame(NWORDS-1, 1'b0, 1'b0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
    chk("t6_err_sat", 64'(o__err_cnt), 64'(exp_err));
    chk("t6_err_sat_ff", 64'(o__err_cnt), 64'hFF);
`endif

    repeat (3) @(negedge clk);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
